// File: rtl/exec_lanes_pkg.sv
// Shared types and constants for the N-lane execute stage: op codes,
// FPU unit indices, divider FSM states and small op-class helpers.
package exec_lanes_pkg;

    typedef enum logic [4:0] {
        E_NOP    = 5'd0,
        E_ADD    = 5'd1,
        E_SUB    = 5'd2,
        E_RSHIFT = 5'd3,
        E_LSHIFT = 5'd4,
        E_XOR    = 5'd5,
        E_AND    = 5'd6,
        E_OR     = 5'd7,
        E_SLT    = 5'd8,
        E_FADD   = 5'd9,
        E_FSUB   = 5'd10,
        E_FMUL   = 5'd11,
        E_FDIV   = 5'd12,
        E_FSQRT  = 5'd13,
        E_FTOI   = 5'd14,
        E_ITOF   = 5'd15,
        E_DIV    = 5'd16,
        E_REM    = 5'd17
    } e_type_t;

    // FPU unit slots inside one lane's group of fu_valid strobes
    localparam int FU_FADD  = 0;
    localparam int FU_FSUB  = 1;
    localparam int FU_FMUL  = 2;
    localparam int FU_FDIV  = 3;
    localparam int FU_FSQRT = 4;
    localparam int FU_FTOI  = 5;
    localparam int FU_ITOF  = 6;

    // Encoding used to fill inst_out while nothing has been captured
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_fpu_op(input logic [4:0] op);
        return (op >= E_FADD) && (op <= E_ITOF);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == E_DIV) || (op == E_REM);
    endfunction

endpackage

// File: rtl/exec_lanes_if.sv
// Bundle interface between register read (master) and the execute stage (slave).
interface exec_lanes_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int RW    = 5,
    parameter int NFU   = 7
);
    logic                   interlock;
    logic                   flush;
    logic [31:0]            pc;
    logic [LANES*32-1:0]    inst;
    logic [LANES*XLEN-1:0]  srca;
    logic [LANES*XLEN-1:0]  srcb;
    logic [LANES*5-1:0]     e_type;
    logic [LANES*RW-1:0]    rt;
    logic [LANES-1:0]       rt_flag;
    logic [31:0]            pc_out;
    logic [LANES*32-1:0]    inst_out;
    logic [LANES*XLEN-1:0]  tdata;
    logic [LANES*RW-1:0]    rt_out;
    logic [LANES-1:0]       rt_flag_out;
    logic [LANES*NFU-1:0]   fu_valid;
    logic [LANES*XLEN-1:0]  fu_srca;
    logic [LANES*XLEN-1:0]  fu_srcb;
    logic [LANES*RW-1:0]    fu_rt;
    logic                   stall_req;
    logic                   illegal;

    modport master (
        output interlock, flush, pc, inst, srca, srcb, e_type, rt, rt_flag,
        input  pc_out, inst_out, tdata, rt_out, rt_flag_out, fu_valid,
               fu_srca, fu_srcb, fu_rt, stall_req, illegal
    );

    modport slave (
        input  interlock, flush, pc, inst, srca, srcb, e_type, rt, rt_flag,
        output pc_out, inst_out, tdata, rt_out, rt_flag_out, fu_valid,
               fu_srca, fu_srcb, fu_rt, stall_req, illegal
    );
endinterface

// File: rtl/exec_lanes_iter_div.sv
// Iterative radix-2 restoring signed divider: one quotient bit per cycle on
// operand magnitudes, sign fix-up and special cases applied on the result.
module iter_div
    import exec_lanes_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_rem,
    input  logic            abort,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONE_V = {{(XLEN-1){1'b0}}, 1'b1};

    div_state_t      state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] quot_r, rem_r, dvsr_r, dvnd_r;
    logic            is_rem_r, neg_q_r, neg_r_r, zero_r;
    logic [XLEN-1:0] abs_a_s, abs_b_s, q_fix_s, r_fix_s;
    logic [XLEN:0]   shift_s, diff_s;

    assign abs_a_s = a[XLEN-1] ? (~a + ONE_V) : a;
    assign abs_b_s = b[XLEN-1] ? (~b + ONE_V) : b;
    assign shift_s = {rem_r, quot_r[XLEN-1]};
    assign diff_s  = shift_s - {1'b0, dvsr_r};
    assign busy    = (state_r != DIV_IDLE);
    assign done    = (state_r == DIV_DONE);

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: abort wins, BUSY runs XLEN cycles, DONE waits for hold to drop
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = DIV_IDLE;
        end else begin
            case (state_r)
                DIV_IDLE: state_s = start ? DIV_BUSY : DIV_IDLE;
                DIV_BUSY: state_s = (cnt_r == CW'(XLEN-1)) ? DIV_DONE : DIV_BUSY;
                DIV_DONE: state_s = hold ? DIV_DONE : DIV_IDLE;
                default:  state_s = DIV_IDLE;
            endcase
        end
    end

    // Operand load on start, one restoring step per BUSY cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r    <= {CW{1'b0}};
            quot_r   <= {XLEN{1'b0}};
            rem_r    <= {XLEN{1'b0}};
            dvsr_r   <= {XLEN{1'b0}};
            dvnd_r   <= {XLEN{1'b0}};
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            zero_r   <= 1'b0;
        end else if ((state_r == DIV_IDLE) && start && !abort) begin
            cnt_r    <= {CW{1'b0}};
            quot_r   <= abs_a_s;
            rem_r    <= {XLEN{1'b0}};
            dvsr_r   <= abs_b_s;
            dvnd_r   <= a;
            is_rem_r <= is_rem;
            neg_q_r  <= a[XLEN-1] ^ b[XLEN-1];
            neg_r_r  <= a[XLEN-1];
            zero_r   <= (b == {XLEN{1'b0}});
        end else if (state_r == DIV_BUSY) begin
            cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            quot_r <= {quot_r[XLEN-2:0], ~diff_s[XLEN]};
            rem_r  <= diff_s[XLEN] ? shift_s[XLEN-1:0] : diff_s[XLEN-1:0];
        end
    end

    // Sign correction and divide-by-zero results
    always_comb begin
        q_fix_s = neg_q_r ? (~quot_r + ONE_V) : quot_r;
        r_fix_s = neg_r_r ? (~rem_r + ONE_V) : rem_r;
        if (zero_r) begin
            result = is_rem_r ? dvnd_r : {XLEN{1'b1}};
        end else begin
            result = is_rem_r ? r_fix_s : q_fix_s;
        end
    end

endmodule

// File: rtl/exec_lanes.sv
// N-lane execute stage: per-lane integer ALU, one-hot FPU dispatch strobes,
// shared lane-0 iterative divider that stalls upstream, and bundle flush.
module exec_lanes
    import exec_lanes_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int RW    = 5,
    parameter int NFU   = 7
) (
    input  logic        clk,
    input  logic        rstn,
    exec_lanes_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    logic [LANES*XLEN-1:0] alu_s, done_tdata_s;
    logic [LANES-1:0]      rtf_s, div_lane_s, ill_lane_s;
    logic [LANES*NFU-1:0]  fuv_s;
    logic                  capture_s, div_start_s, div_busy_s, div_done_s, is_rem_s;
    logic [XLEN-1:0]       div_res_s;

    logic [31:0]           pc_r, h_pc_r;
    logic [LANES*32-1:0]   inst_r, h_inst_r;
    logic [LANES*XLEN-1:0] tdata_r, h_tdata_r, fsa_r, h_fsa_r, fsb_r, h_fsb_r;
    logic [LANES*RW-1:0]   rt_r, h_rt_r;
    logic [LANES-1:0]      rtf_r, h_rtf_r;
    logic [LANES*NFU-1:0]  fuv_r, h_fuv_r;
    logic                  ill_r;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [XLEN-1:0] a_s, b_s, res_s;
        logic [4:0]      op_s;

        assign a_s  = bus.srca[i*XLEN +: XLEN];
        assign b_s  = bus.srcb[i*XLEN +: XLEN];
        assign op_s = bus.e_type[i*5 +: 5];

        // Integer result for this lane; FPU and divide lanes yield zero here
        always_comb begin
            res_s = b_s;
            case (op_s)
                E_NOP:    res_s = b_s;
                E_ADD:    res_s = a_s + b_s;
                E_SUB:    res_s = a_s - b_s;
                E_RSHIFT: res_s = $signed(a_s) >>> b_s[SHW-1:0];
                E_LSHIFT: res_s = a_s << b_s[SHW-1:0];
                E_XOR:    res_s = a_s ^ b_s;
                E_AND:    res_s = a_s & b_s;
                E_OR:     res_s = a_s | b_s;
                E_SLT:    res_s = {{(XLEN-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
                E_FADD, E_FSUB, E_FMUL, E_FDIV, E_FSQRT, E_FTOI, E_ITOF,
                E_DIV, E_REM: res_s = {XLEN{1'b0}};
                default:  res_s = b_s;
            endcase
        end

        assign alu_s[i*XLEN +: XLEN] = res_s;
        assign div_lane_s[i] = is_div_op(op_s);
        assign ill_lane_s[i] = div_lane_s[i] && (i > 0);
        assign rtf_s[i]      = bus.rt_flag[i] && !is_fpu_op(op_s) && !ill_lane_s[i];

        for (genvar u = 0; u < NFU; u++) begin : g_fu
            assign fuv_s[i*NFU+u] = bus.rt_flag[i] && (op_s == (E_FADD + 5'(u)));
        end
    end

    assign capture_s   = !div_busy_s && !bus.interlock && !bus.flush;
    assign div_start_s = capture_s && div_lane_s[0];
    assign is_rem_s    = (bus.e_type[4:0] == E_REM);

    iter_div #(.XLEN(XLEN)) u_div (
        .clk    (clk),
        .rstn   (rstn),
        .start  (div_start_s),
        .a      (bus.srca[XLEN-1:0]),
        .b      (bus.srcb[XLEN-1:0]),
        .is_rem (is_rem_s),
        .abort  (bus.flush),
        .hold   (bus.interlock),
        .busy   (div_busy_s),
        .done   (div_done_s),
        .result (div_res_s)
    );

    // Parked divide bundle with the lane-0 slot replaced by the divider result
    always_comb begin
        done_tdata_s = h_tdata_r;
        done_tdata_s[XLEN-1:0] = div_res_s;
    end

    // Park the whole bundle while lane 0 divides
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_pc_r    <= 32'h0000_0000;
            h_inst_r  <= {LANES{NOP_INST}};
            h_tdata_r <= {(LANES*XLEN){1'b0}};
            h_fsa_r   <= {(LANES*XLEN){1'b0}};
            h_fsb_r   <= {(LANES*XLEN){1'b0}};
            h_rt_r    <= {(LANES*RW){1'b0}};
            h_rtf_r   <= {LANES{1'b0}};
            h_fuv_r   <= {(LANES*NFU){1'b0}};
        end else if (div_start_s) begin
            h_pc_r    <= bus.pc;
            h_inst_r  <= bus.inst;
            h_tdata_r <= alu_s;
            h_fsa_r   <= bus.srca;
            h_fsb_r   <= bus.srcb;
            h_rt_r    <= bus.rt;
            h_rtf_r   <= rtf_s;
            h_fuv_r   <= fuv_s;
        end
    end

    // Output stage: flush kills, finished divide lands, else capture or hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_r    <= 32'h0000_0000;
            inst_r  <= {LANES{NOP_INST}};
            tdata_r <= {(LANES*XLEN){1'b0}};
            fsa_r   <= {(LANES*XLEN){1'b0}};
            fsb_r   <= {(LANES*XLEN){1'b0}};
            rt_r    <= {(LANES*RW){1'b0}};
            rtf_r   <= {LANES{1'b0}};
            fuv_r   <= {(LANES*NFU){1'b0}};
            ill_r   <= 1'b0;
        end else if (bus.flush) begin
            rtf_r <= {LANES{1'b0}};
            fuv_r <= {(LANES*NFU){1'b0}};
            ill_r <= 1'b0;
        end else if (div_done_s && !bus.interlock) begin
            pc_r    <= h_pc_r;
            inst_r  <= h_inst_r;
            tdata_r <= done_tdata_s;
            fsa_r   <= h_fsa_r;
            fsb_r   <= h_fsb_r;
            rt_r    <= h_rt_r;
            rtf_r   <= h_rtf_r;
            fuv_r   <= h_fuv_r;
            ill_r   <= 1'b0;
        end else if (capture_s) begin
            ill_r <= |ill_lane_s;
            if (div_start_s) begin
                rtf_r <= {LANES{1'b0}};
                fuv_r <= {(LANES*NFU){1'b0}};
            end else begin
                pc_r    <= bus.pc;
                inst_r  <= bus.inst;
                tdata_r <= alu_s;
                fsa_r   <= bus.srca;
                fsb_r   <= bus.srcb;
                rt_r    <= bus.rt;
                rtf_r   <= rtf_s;
                fuv_r   <= fuv_s;
            end
        end else begin
            fuv_r <= {(LANES*NFU){1'b0}};
            ill_r <= 1'b0;
        end
    end

    assign bus.pc_out      = pc_r;
    assign bus.inst_out    = inst_r;
    assign bus.tdata       = tdata_r;
    assign bus.rt_out      = rt_r;
    assign bus.rt_flag_out = rtf_r;
    assign bus.fu_valid    = fuv_r;
    assign bus.fu_srca     = fsa_r;
    assign bus.fu_srcb     = fsb_r;
    assign bus.fu_rt       = rt_r;
    assign bus.stall_req   = div_busy_s;
    assign bus.illegal     = ill_r;

endmodule

// File: tb/tb_exec_lanes.sv
// Directed bench for exec_lanes: table of single-cycle ALU/FPU bundles, then
// hand-written sequences for divide timing, interlock, flush, illegal and reset.
module tb_exec_lanes;
    import exec_lanes_pkg::*;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int RW    = 5;
    localparam int NFU   = 7;
    localparam int NV    = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    exec_lanes_if #(.LANES(LANES), .XLEN(XLEN), .RW(RW), .NFU(NFU)) bus ();

    exec_lanes #(.LANES(LANES), .XLEN(XLEN), .RW(RW), .NFU(NFU)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [4:0]  op0;
        logic [31:0] a0, b0;
        logic [4:0]  op1;
        logic [31:0] a1, b1;
        logic [1:0]  rtf;
        logic [31:0] e0, e1;
        logic [1:0]  ertf;
        logic [13:0] efuv;
        bit          chk0;
    } vec_t;

    vec_t vecs [NV];
    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [1:0] rtf);
        bus.e_type  = {op1, op0};
        bus.srca    = {a1, a0};
        bus.srcb    = {b1, b0};
        bus.rt_flag = rtf;
    endtask

    // Lane-0 divide with inputs changed while busy; checks stall length and result
    task automatic run_div(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int stall_cnt;
        bus.pc = 32'h0000_2000;
        drive(op, a, b, E_NOP, 32'd0, 32'd0, 2'b01);
        step();
        chk({name, " bubble rtf"}, 64'(bus.rt_flag_out), 64'd0);
        bus.pc = 32'h0000_3333;
        drive(E_ADD, 32'd1, 32'd1, E_ADD, 32'd1, 32'd1, 2'b11);
        stall_cnt = 0;
        while (bus.stall_req === 1'b1 && stall_cnt < 100) begin
            stall_cnt++;
            step();
        end
        chk({name, " stall cycles"}, 64'(stall_cnt), 64'd33);
        chk({name, " result"}, 64'(bus.tdata[31:0]), 64'(exp));
        chk({name, " rtf"}, 64'(bus.rt_flag_out), 64'd1);
        chk({name, " pc"}, 64'(bus.pc_out), 64'h2000);
        drive(E_NOP, 32'd0, 32'd0, E_NOP, 32'd0, 32'd0, 2'b00);
    endtask

    initial begin
        vecs[0] = '{E_ADD, 32'd7, 32'hFFFF_FFFD, E_SLT, 32'hFFFF_FFFF, 32'd2, 2'b11,
                    32'd4, 32'd1, 2'b11, 14'h0000, 1'b1};
        vecs[1] = '{E_SUB, 32'd5, 32'd8, E_XOR, 32'h0000_F0F0, 32'h0000_FF00, 2'b11,
                    32'hFFFF_FFFD, 32'h0000_0FF0, 2'b11, 14'h0000, 1'b1};
        vecs[2] = '{E_RSHIFT, 32'h8000_0000, 32'd4, E_LSHIFT, 32'd1, 32'd33, 2'b10,
                    32'hF800_0000, 32'd2, 2'b10, 14'h0000, 1'b1};
        vecs[3] = '{E_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, E_OR, 32'h1, 32'h100, 2'b01,
                    32'h0F00_0F00, 32'h0000_0101, 2'b01, 14'h0000, 1'b1};
        vecs[4] = '{E_NOP, 32'd5, 32'd9, E_SLT, 32'd3, 32'hFFFF_FFFE, 2'b11,
                    32'd9, 32'd0, 2'b11, 14'h0000, 1'b1};
        vecs[5] = '{5'd31, 32'd77, 32'h0000_1234, E_ADD, 32'h7FFF_FFFF, 32'd1, 2'b11,
                    32'h0000_1234, 32'h8000_0000, 2'b11, 14'h0000, 1'b1};
        vecs[6] = '{E_FADD, 32'd1, 32'd2, E_ADD, 32'd1, 32'd1, 2'b10,
                    32'd0, 32'd2, 2'b10, 14'h0000, 1'b0};
        vecs[7] = '{E_FSQRT, 32'd1, 32'd2, E_LSHIFT, 32'h8000_0001, 32'd31, 2'b11,
                    32'd0, 32'h8000_0000, 2'b10, 14'h0010, 1'b0};

        rstn = 1'b0;
        bus.interlock = 1'b0;
        bus.flush = 1'b0;
        bus.pc = 32'h0;
        bus.inst = {32'hAAAA_0001, 32'h5555_0002};
        bus.rt = {5'd9, 5'd5};
        drive(E_NOP, 32'd0, 32'd0, E_NOP, 32'd0, 32'd0, 2'b00);
        #12;
        chk("reset pc_out", 64'(bus.pc_out), 64'd0);
        chk("reset inst_out", 64'(bus.inst_out), 64'd0);
        chk("reset tdata", 64'(bus.tdata), 64'd0);
        chk("reset rt_flag_out", 64'(bus.rt_flag_out), 64'd0);
        chk("reset fu_valid", 64'(bus.fu_valid), 64'd0);
        chk("reset stall/illegal", 64'({bus.stall_req, bus.illegal}), 64'd0);
        chk("reset fu_srca", 64'(bus.fu_srca), 64'd0);
        rstn = 1'b1;

        // table of single-cycle bundles
        for (int i = 0; i < NV; i++) begin
            bus.pc = 32'h0000_1000 + 32'(i * 4);
            drive(vecs[i].op0, vecs[i].a0, vecs[i].b0, vecs[i].op1, vecs[i].a1, vecs[i].b1,
                  vecs[i].rtf);
            step();
            if (vecs[i].chk0)
                chk($sformatf("vec%0d tdata0", i), 64'(bus.tdata[31:0]), 64'(vecs[i].e0));
            chk($sformatf("vec%0d tdata1", i), 64'(bus.tdata[63:32]), 64'(vecs[i].e1));
            chk($sformatf("vec%0d rt_flag_out", i), 64'(bus.rt_flag_out), 64'(vecs[i].ertf));
            chk($sformatf("vec%0d fu_valid", i), 64'(bus.fu_valid), 64'(vecs[i].efuv));
            chk($sformatf("vec%0d pc_out", i), 64'(bus.pc_out), 64'(32'h0000_1000 + 32'(i * 4)));
        end
        chk("inst_out pass", 64'(bus.inst_out), 64'hAAAA_0001_5555_0002);

        // FPU strobe: lane0 fmul, lane1 itof
        bus.pc = 32'h0000_0400;
        drive(E_FMUL, 32'h3F80_0000, 32'h4000_0000, E_ITOF, 32'd3, 32'd0, 2'b11);
        step();
        chk("fpu fu_valid", 64'(bus.fu_valid), 64'h2004);
        chk("fpu fu_rt0", 64'(bus.fu_rt[4:0]), 64'd5);
        chk("fpu fu_srca0", 64'(bus.fu_srca[31:0]), 64'h3F80_0000);
        chk("fpu rt_flag_out", 64'(bus.rt_flag_out), 64'd0);
        bus.interlock = 1'b1;
        bus.pc = 32'h0000_0500;
        step();
        chk("fpu interlock fu_valid", 64'(bus.fu_valid), 64'd0);
        chk("interlock holds pc", 64'(bus.pc_out), 64'h0400);
        bus.interlock = 1'b0;
        drive(E_NOP, 32'd0, 32'd0, E_NOP, 32'd0, 32'd0, 2'b00);
        step();
        chk("fpu strobe gone", 64'(bus.fu_valid), 64'd0);

        // divides
        run_div("div -7/2", E_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("rem -7/2", E_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("div 5/0", E_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_div("rem 5/0", E_REM, 32'd5, 32'd0, 32'd5);
        run_div("div min/-1", E_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem min/-1", E_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_div("div 100/7", E_DIV, 32'd100, 32'd7, 32'd14);
        run_div("rem 7/-2", E_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);

        // interlock held through BUSY and DONE
        drive(E_DIV, 32'd20, 32'd3, E_NOP, 32'd0, 32'd0, 2'b01);
        step();
        bus.interlock = 1'b1;
        for (int k = 0; k < 40; k++) step();
        chk("hold stall", 64'(bus.stall_req), 64'd1);
        chk("hold rtf", 64'(bus.rt_flag_out), 64'd0);
        bus.interlock = 1'b0;
        step();
        chk("hold release stall", 64'(bus.stall_req), 64'd0);
        chk("hold release result", 64'(bus.tdata[31:0]), 64'd6);
        drive(E_NOP, 32'd0, 32'd0, E_NOP, 32'd0, 32'd0, 2'b00);

        // flush in BUSY cycle 10
        drive(E_DIV, 32'd100, 32'd7, E_NOP, 32'd0, 32'd0, 2'b01);
        step();
        drive(E_NOP, 32'd0, 32'd0, E_NOP, 32'd0, 32'd0, 2'b00);
        for (int k = 0; k < 9; k++) step();
        chk("pre-flush stall", 64'(bus.stall_req), 64'd1);
        bus.flush = 1'b1;
        step();
        chk("flush stall", 64'(bus.stall_req), 64'd0);
        chk("flush rtf", 64'(bus.rt_flag_out), 64'd0);
        chk("flush fu_valid", 64'(bus.fu_valid), 64'd0);
        bus.flush = 1'b0;
        drive(E_ADD, 32'd2, 32'd3, E_NOP, 32'd0, 32'd0, 2'b01);
        step();
        chk("post-flush add", 64'(bus.tdata[31:0]), 64'd5);
        chk("post-flush rtf", 64'(bus.rt_flag_out), 64'd1);

        // divide on lane 1
        drive(E_ADD, 32'd1, 32'd2, E_DIV, 32'd6, 32'd3, 2'b11);
        step();
        chk("illegal pulse", 64'(bus.illegal), 64'd1);
        chk("illegal tdata1", 64'(bus.tdata[63:32]), 64'd0);
        chk("illegal tdata0", 64'(bus.tdata[31:0]), 64'd3);
        chk("illegal rtf", 64'(bus.rt_flag_out), 64'd1);
        chk("illegal no stall", 64'(bus.stall_req), 64'd0);
        drive(E_NOP, 32'd0, 32'd0, E_NOP, 32'd0, 32'd0, 2'b00);
        step();
        chk("illegal cleared", 64'(bus.illegal), 64'd0);

        // reset in the middle of a divide
        bus.pc = 32'h0000_7000;
        drive(E_ADD, 32'd10, 32'd10, E_NOP, 32'd0, 32'd0, 2'b01);
        step();
        drive(E_DIV, 32'hFFFF_FFF9, 32'd2, E_NOP, 32'd0, 32'd0, 2'b01);
        step();
        for (int k = 0; k < 4; k++) step();
        #2;
        rstn = 1'b0;
        #1;
        chk("midreset pc_out", 64'(bus.pc_out), 64'd0);
        chk("midreset tdata", 64'(bus.tdata), 64'd0);
        chk("midreset stall", 64'(bus.stall_req), 64'd0);
        chk("midreset rtf", 64'(bus.rt_flag_out), 64'd0);
        rstn = 1'b1;
        drive(E_ADD, 32'd4, 32'd4, E_NOP, 32'd0, 32'd0, 2'b01);
        step();
        chk("after reset add", 64'(bus.tdata[31:0]), 64'd8);
        chk("after reset stall", 64'(bus.stall_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/exec_lanes.md
# exec_lanes

Parametrised N-lane execute stage for the in-order superscalar core, replacing the fixed two-lane execute stage. It sits between register read/forwarding and memory/writeback. Each cycle it computes integer ALU results for every lane and dispatches floating-point operations to the FPU units through one-hot valid strobes. It adds a shared iterative signed divider on lane 0 that stalls upstream while busy, plus a pipeline flush.

## Interface
Parameters:
- `LANES`, default 2: number of issue lanes.
- `XLEN`, default 32: datapath width.
- `RW`, default 5: register index width.
- `NFU`, default 7: FPU unit count, in order fadd, fsub, fmul, fdiv, fsqrt, ftoi, itof.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous and active-low.
- `interlock`  in  1  hold: no capture, outputs keep their values.
- `flush`  in  1  kill the in-flight bundle.
- `pc`  in  32  bundle PC.
- `inst`  in  LANES*32  bundle instructions; lane i occupies [32i+31:32i].
- `srca`, `srcb`  in  LANES*XLEN  operands.
- `e_type`  in  LANES*5  op code per lane (`e_type_t`).
- `rt`  in  LANES*RW  destination registers.
- `rt_flag`  in  LANES  writeback enable per lane.
- `pc_out`  out  32  registered PC.
- `inst_out`  out  LANES*32  registered instructions.
- `tdata`  out  LANES*XLEN  integer results.
- `rt_out`  out  LANES*RW  registered destinations.
- `rt_flag_out`  out  LANES  writeback enables.
- `fu_valid`  out  LANES*NFU  one-hot FPU issue strobe; bit [NFU*i+u] addresses lane i, unit u.
- `fu_srca`, `fu_srcb`  out  LANES*XLEN  FPU operands.
- `fu_rt`  out  LANES*RW  FPU destination.
- `stall_req`  out  1  divider busy; upstream must hold its inputs.
- `illegal`  out  1  one-cycle pulse when a divide op is issued on lane ≥1.

## Operation
- Ops:
  - ENop=0 gives srcb.
  - EAdd=1 and ESub=2 are signed add and subtract.
  - ERshift=3 is an arithmetic right shift; ELshift=4 is a left shift. Both use srcb[log2(XLEN)-1:0] as the shift amount.
  - EXor=5, EAnd=6 and EOr=7 are bitwise.
  - ESlt=8 gives 1 if srca is less than srcb (signed), else 0.
  - EFadd..EItof=9..15 are FPU ops.
  - EDiv=16 and ERem=17 are divide ops.
  - Undefined codes behave as ENop.
- FPU dispatch:
  - e_type 9..15 sets the corresponding `fu_valid` bit only when rt_flag=1.
  - `fu_srca/fu_srcb/fu_rt` are loaded for every captured bundle.
  - `rt_flag_out` is forced to 0 for FPU lanes; writeback comes from the FPU.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY: lane 0 has e_type EDiv or ERem, the stage is capturing, and flush=0. The whole bundle is latched, and `rt_flag_out` and `fu_valid` are 0 (bubble).
  - BUSY: radix-2 restoring division on operand magnitudes, one quotient bit per cycle, XLEN cycles, then →DONE.
  - DONE with interlock=0: writes the bundle to the outputs, with the lane-0 quotient or remainder sign-corrected, then →IDLE.
  - DONE with interlock=1: waits in DONE.
  - Inputs are ignored while the state is not IDLE.
- Divide special cases:
  - Divide by 0: quotient all ones, remainder = srca.
  - Most-negative / -1: quotient = most-negative, remainder = 0.
  - Remainder takes the sign of the dividend.
- Divide on lane ≥1: the result is 0 with rt_flag_out=0, and `illegal` pulses.
- flush=1 has priority over capture and interlock:
  - next edge: all `rt_flag_out` and `fu_valid` are 0, and the FSM goes →IDLE, aborting any divide.

## Timing
- Reset values (async): `pc_out` 0, `inst_out` all Nop, `tdata` 0, `rt_out` 0, `rt_flag_out` 0, `fu_valid` 0, `fu_srca`, `fu_srcb` and `fu_rt` 0, `stall_req` 0, `illegal` 0, FSM IDLE.
- Non-divide bundles have 1-cycle latency: inputs sampled at edge k appear after edge k.
- `fu_valid` is a single-cycle strobe:
  - cleared on the next edge unless a new FPU op is captured;
  - also cleared on edges where interlock=1.
- Divide latency is XLEN+2 edges from capture to outputs when interlock=0.
- `stall_req` is Moore: 1 in BUSY and DONE.
- Interlock during BUSY does not pause the iteration.
- Reset asserted mid-divide: the FSM returns to IDLE immediately and all outputs take their reset values.

## Structure
- Extend `inst_package`:
  - 5-bit `e_type_t` enum with the codes above;
  - FPU unit index constants FU_FADD..FU_ITOF = 0..6.
- ALU function as a combinational per-lane generate loop.
- One sub-module, `iter_div`: holds the FSM, counter, operand/remainder registers and sign fix-up.
  - ports: start, a, b, is_rem, abort, hold, busy, done, result.

## Test plan
1. LANES=2, lane0 EAdd 7+(-3), lane1 ESlt -1<2, rt_flag=11 → next cycle tdata0=4, tdata1=1, rt_flag_out=11.
2. Lane0 EFmul with rt=5 → `fu_valid` bit [2] high for exactly one cycle, fu_rt0=5, rt_flag_out0=0; interlock=1 on the following cycle keeps it 0.
3. Lane0 EDiv -7/2 → `stall_req` high for XLEN+1 cycles, tdata0=-3 at edge XLEN+2; ERem -7/2 → -1.
4. EDiv 5/0 → 0xFFFFFFFF; ERem 5/0 → 5; EDiv 0x80000000/-1 → 0x80000000.
5. flush asserted in BUSY cycle 10 → next edge `stall_req`=0, `rt_flag_out`=0, and a fresh EAdd is accepted on the following cycle.
6. Lane1 EDiv → `illegal` pulses once, tdata1=0, rt_flag_out1=0; rstn dropped mid-divide → all outputs take their reset values asynchronously.
